dump_ctrl: RTL

- Readout stage directly downstream of the capture controller in the logic-analyzer datapath.
- After a capture completes, it reads the circular sample RAM of one selected channel, starting at the oldest sample, and streams every entry byte-by-byte to the UART transmitter.
- When the stream ends it clears capture_done in cmd_cfg, which re-enables capture.

---
 rtl/la_pkg.sv | 14 +
 rtl/dump_addr_gen.sv | 35 +++
 rtl/dump_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/la_pkg.sv
// Constants and state encoding shared by the logic-analyzer capture and readout blocks.
package la_pkg;
  localparam int ENTRIES  = 384;
  localparam int LOG2     = 9;
  localparam int CHANNELS = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LOAD,
    WAIT_TX,
    DONE
  } dump_state_t;
endpackage

// File: rtl/dump_addr_gen.sv
// Readout address generator: loads the oldest-sample address, wraps at ENTRIES-1, flags the last byte.
// Single-cycle register updates; advances only when the controller asks, so it never stalls itself.
module dump_addr_gen
  import la_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            adv,
  input  logic [LOG2-1:0] start_addr,
  output logic [LOG2-1:0] raddr,
  output logic            last
);

  localparam logic [LOG2-1:0] LAST_IDX = LOG2'(ENTRIES - 1);

  logic [LOG2-1:0] byte_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr    <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      raddr    <= start_addr;
      byte_cnt <= '0;
    end else if (adv) begin
      // The RAM is ENTRIES deep, not a power of two, so the wrap is explicit.
      raddr    <= (raddr == LAST_IDX) ? '0 : raddr + LOG2'(1);
      byte_cnt <= byte_cnt + LOG2'(1);
    end
  end

  assign last = (byte_cnt == LAST_IDX);

endmodule

// File: rtl/dump_ctrl.sv
// Streams one channel's circular sample RAM, oldest first, to the UART; first trmt 3 cycles after accept.
// One byte in flight at a time: each next RAM read waits for tx_done from the UART.
module dump_ctrl
  import la_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump_start,
  input  logic [2:0]      dump_chan,
  input  logic            capture_done,
  input  logic [LOG2-1:0] start_addr,
  input  logic [7:0]      rdata,
  input  logic            tx_done,
  output logic [LOG2-1:0] raddr,
  output logic [2:0]      ram_sel,
  output logic [7:0]      tx_data,
  output logic            trmt,
  output logic            dump_busy,
  output logic            dump_done,
  output logic            clr_capture_done,
  output logic            dump_rej
);

  dump_state_t state;
  logic        accept;
  logic        adv;
  logic        last;

  assign accept = (state == IDLE) && dump_start && capture_done &&
                  (dump_chan < 3'(CHANNELS));
  assign adv    = (state == WAIT_TX) && tx_done && !last;

  dump_addr_gen u_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .adv        (adv),
    .start_addr (start_addr),
    .raddr      (raddr),
    .last       (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ram_sel          <= '0;
      tx_data          <= '0;
      trmt             <= 1'b0;
      dump_busy        <= 1'b0;
      dump_done        <= 1'b0;
      clr_capture_done <= 1'b0;
      dump_rej         <= 1'b0;
    end else begin
      trmt             <= 1'b0;
      dump_done        <= 1'b0;
      clr_capture_done <= 1'b0;
      dump_rej         <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ram_sel   <= dump_chan;
            dump_busy <= 1'b1;
            state     <= RD;
          end else if (dump_start) begin
            dump_rej <= 1'b1;
          end
        end
        RD: state <= LOAD;
        LOAD: begin
          tx_data <= rdata;
          trmt    <= 1'b1;
          state   <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done) state <= last ? DONE : RD;
        end
        DONE: begin
          dump_done        <= 1'b1;
          clr_capture_done <= 1'b1;
          dump_busy        <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
